// File: rtl/ps2_pkg.sv
// PS/2 mouse transmitter shared types: FSM states, frame geometry, parity.
// Imported by the line synchroniser, the bus interface and the transmitter top.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    WAIT_ACK,
    WAIT_IDLE,
    DONE
  } tx_state_e;

  localparam int FRAME_DATA_BITS = 8;
  localparam int FRAME_LAST_EDGE = 10;

  function automatic logic odd_parity(
    input logic [FRAME_DATA_BITS-1:0] b
  );
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_mouse_transmitter_if.sv
// PS/2 transmitter bus: mouse line samples, pad enables and host byte request.
// master = transmitter side, slave = host/pad/device side.
interface ps2_mouse_transmitter_if;
  import ps2_pkg::*;

  logic                       CLK_MOUSE_IN;
  logic                       CLK_MOUSE_OUT_EN;
  logic                       DATA_MOUSE_IN;
  logic                       DATA_MOUSE_OUT;
  logic                       DATA_MOUSE_OUT_EN;
  logic                       SEND_BYTE;
  logic [FRAME_DATA_BITS-1:0] BYTE_TO_SEND;
  logic                       BYTE_SENT;

  modport master (
    input  CLK_MOUSE_IN,
    input  DATA_MOUSE_IN,
    input  SEND_BYTE,
    input  BYTE_TO_SEND,
    output CLK_MOUSE_OUT_EN,
    output DATA_MOUSE_OUT,
    output DATA_MOUSE_OUT_EN,
    output BYTE_SENT
  );

  modport slave (
    output CLK_MOUSE_IN,
    output DATA_MOUSE_IN,
    output SEND_BYTE,
    output BYTE_TO_SEND,
    input  CLK_MOUSE_OUT_EN,
    input  DATA_MOUSE_OUT,
    input  DATA_MOUSE_OUT_EN,
    input  BYTE_SENT
  );

endinterface

// File: rtl/ps2_line_sync.sv
// 2-FF synchroniser for one PS/2 line plus a 1-cycle falling-edge strobe.
// Ports: clk_i, rst_ni (async low), line_i -> sync_o, fall_o.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the idle-high bus level so release of reset never
  // fakes a falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_mouse_transmitter.sv
// PS/2 host-to-device byte transmitter: inhibit, RTS, 11-bit frame, ACK check.
// Ports: CLK, RESET (async low), bus (master). Option: MOUSE_TX_TIMEOUT_EN watchdog.
module ps2_mouse_transmitter
  import ps2_pkg::*;
#(
  parameter int CLK_INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES     = 200000
) (
  input logic                     CLK,
  input logic                     RESET,
  ps2_mouse_transmitter_if.master bus
);

  tx_state_e                  state_q;
  logic [FRAME_DATA_BITS-1:0] byte_q;
  logic                       par_q;
  logic [31:0]                cnt_q;
  logic [3:0]                 bit_q;
  logic                       clk_en_q;
  logic                       dat_en_q;
  logic                       dat_q;
  logic                       sent_q;

  logic clk_sync;
  logic clk_fall;
  logic dat_sync;
  logic data_fall_unused;
  logic wd_hit;

  ps2_line_sync u_clk_sync (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .line_i (bus.CLK_MOUSE_IN),
    .sync_o (clk_sync),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .line_i (bus.DATA_MOUSE_IN),
    .sync_o (dat_sync),
    .fall_o (data_fall_unused)
  );

`ifdef MOUSE_TX_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        wd_run;

  assign wd_run = state_q inside {SEND, WAIT_ACK, WAIT_IDLE};
  // A device edge in the same cycle wins over the timeout.
  assign wd_hit = wd_run && !clk_fall &&
                  (wd_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wd_q <= '0;
    end else if (!wd_run || clk_fall || wd_hit) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT_CYCLES);
  assign wd_hit         = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      byte_q   <= '0;
      par_q    <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      clk_en_q <= 1'b0;
      dat_en_q <= 1'b0;
      dat_q    <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      sent_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          clk_en_q <= 1'b0;
          dat_en_q <= 1'b0;
          dat_q    <= 1'b0;
          cnt_q    <= '0;
          bit_q    <= '0;
          if (bus.SEND_BYTE) begin
            byte_q   <= bus.BYTE_TO_SEND;
            par_q    <= odd_parity(bus.BYTE_TO_SEND);
            clk_en_q <= 1'b1;
            state_q  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_q == 32'(CLK_INHIBIT_CYCLES - 1)) begin
            cnt_q    <= '0;
            dat_en_q <= 1'b1;
            dat_q    <= 1'b0;
            state_q  <= REQ;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        REQ: begin
          clk_en_q <= 1'b0;
          state_q  <= SEND;
        end
        SEND: begin
          if (wd_hit) begin
            dat_en_q <= 1'b0;
            dat_q    <= 1'b0;
            state_q  <= IDLE;
          end else if (clk_fall) begin
            bit_q <= bit_q + 4'd1;
            // Edge 10 releases data; the pull-up forms the stop bit.
            if (bit_q == 4'(FRAME_LAST_EDGE - 1)) begin
              dat_en_q <= 1'b0;
              dat_q    <= 1'b0;
              state_q  <= WAIT_ACK;
            end else if (bit_q < 4'(FRAME_DATA_BITS)) begin
              dat_q <= byte_q[bit_q[2:0]];
            end else begin
              dat_q <= par_q;
            end
          end
        end
        WAIT_ACK: begin
          if (wd_hit) begin
            state_q <= IDLE;
          end else if (clk_fall) begin
            state_q <= dat_sync ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (wd_hit) begin
            state_q <= IDLE;
          end else if (clk_sync && dat_sync) begin
            sent_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          clk_en_q <= 1'b0;
          dat_en_q <= 1'b0;
          dat_q    <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.CLK_MOUSE_OUT_EN  = clk_en_q;
  assign bus.DATA_MOUSE_OUT_EN = dat_en_q;
  assign bus.DATA_MOUSE_OUT    = dat_q;
  assign bus.BYTE_SENT         = sent_q;

endmodule

// File: tb/tb_ps2_mouse_transmitter.sv
// Directed bench for ps2_mouse_transmitter with an open-collector device model.
// Shortened inhibit/timeout parameters keep the run short.
module tb_ps2_mouse_transmitter;

  localparam int INH = 200;
  localparam int TMO = 2000;
  localparam int H   = 20;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int clk_en_cyc = 0;
  int sent_cnt = 0;
  int act_cnt = 0;
  logic en_at_ack = 1'b0;

  ps2_mouse_transmitter_if bus ();

  ps2_mouse_transmitter #(
    .CLK_INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.CLK_MOUSE_IN  = dev_clk & ~bus.CLK_MOUSE_OUT_EN;
  assign bus.DATA_MOUSE_IN = bus.DATA_MOUSE_OUT_EN ?
                             bus.DATA_MOUSE_OUT : dev_data;

  always @(negedge clk) begin
    if (bus.CLK_MOUSE_OUT_EN) clk_en_cyc++;
    if (bus.BYTE_SENT) sent_cnt++;
    if (rst_n && (bus.CLK_MOUSE_OUT_EN || bus.DATA_MOUSE_OUT_EN ||
                  bus.DATA_MOUSE_OUT || bus.BYTE_SENT))
      act_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.CLK_MOUSE_OUT_EN, bus.DATA_MOUSE_OUT_EN,
            bus.DATA_MOUSE_OUT, bus.BYTE_SENT};
  endfunction

  task automatic request(input logic [7:0] b, input bit hold);
    @(negedge clk);
    bus.BYTE_TO_SEND = b;
    bus.SEND_BYTE    = 1'b1;
    @(negedge clk);
    if (!hold) bus.SEND_BYTE = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    int n;
    n = 0;
    while (!bus.CLK_MOUSE_OUT_EN && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.CLK_MOUSE_OUT_EN && n < INH + 50) begin
      @(negedge clk);
      n++;
    end
    ok = !bus.CLK_MOUSE_OUT_EN;
  endtask

  // Device clocking: bits[k] is the data line just before falling edge k+1.
  task automatic dev_clocks(input int n, input bit ack,
                            output logic [10:0] bits);
    bits = '1;
    for (int k = 0; k < n; k++) begin
      repeat (H) @(negedge clk);
      bits[k] = bus.DATA_MOUSE_IN;
      if (k == 10) begin
        en_at_ack = bus.DATA_MOUSE_OUT_EN;
        if (ack) dev_data = 1'b0;
      end
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
    end
    repeat (H) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_sent();
    int n;
    n = 0;
    while (sent_cnt == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  logic [10:0] bits;
  bit ok;

  initial begin
    bus.SEND_BYTE    = 1'b0;
    bus.BYTE_TO_SEND = 8'h00;

    #50;
    check("reset_outs", 32'(outs()), 32'h0);
    #50;
    rst_n = 1'b1;

    act_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      repeat (H) @(negedge clk);
      dev_clk = ~dev_clk;
    end
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_quiet", 32'(act_cnt), 32'h0);

    // 0x99: four ones -> odd parity 1.
    clk_en_cyc = 0;
    sent_cnt   = 0;
    request(8'h99, 1'b0);
    wait_release(ok);
    check("f99_release", 32'(ok), 32'h1);
    check("f99_inhibit", 32'(clk_en_cyc), 32'(INH + 1));
    bus.BYTE_TO_SEND = 8'h00;
    dev_clocks(11, 1'b1, bits);
    check("f99_start", 32'(bits[0]), 32'h0);
    check("f99_data", 32'(bits[8:1]), 32'h99);
    check("f99_par", 32'(bits[9]), 32'h1);
    check("f99_stop", 32'(bits[10]), 32'h1);
    check("f99_rel10", 32'(en_at_ack), 32'h0);
    wait_sent();
    check("f99_sent", 32'(sent_cnt), 32'h1);

    // 0xF4: five ones -> parity 0; request held high.
    sent_cnt = 0;
    request(8'hF4, 1'b1);
    wait_release(ok);
    check("ff4_release", 32'(ok), 32'h1);
    dev_clocks(11, 1'b1, bits);
    check("ff4_start", 32'(bits[0]), 32'h0);
    check("ff4_data", 32'(bits[8:1]), 32'hF4);
    check("ff4_par", 32'(bits[9]), 32'h0);
    check("ff4_stop", 32'(bits[10]), 32'h1);
    wait_sent();
    check("ff4_sent", 32'(sent_cnt), 32'h1);
    check("ff4_retrig", 32'(bus.CLK_MOUSE_OUT_EN), 32'h1);
    bus.SEND_BYTE = 1'b0;

    // Re-triggered 0xF4 frame answered with NACK.
    sent_cnt = 0;
    wait_release(ok);
    check("nak_release", 32'(ok), 32'h1);
    dev_clocks(11, 1'b0, bits);
    check("nak_data", 32'(bits[8:1]), 32'hF4);
    repeat (20) @(negedge clk);
    check("nak_sent", 32'(sent_cnt), 32'h0);
    check("nak_outs", 32'(outs()), 32'h0);

    // Reset in the middle of SEND.
    request(8'h3C, 1'b0);
    wait_release(ok);
    dev_clocks(4, 1'b1, bits);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", 32'(outs()), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 0xA5: four ones -> parity 1.
    sent_cnt = 0;
    request(8'hA5, 1'b0);
    wait_release(ok);
    check("fa5_release", 32'(ok), 32'h1);
    dev_clocks(11, 1'b1, bits);
    check("fa5_data", 32'(bits[8:1]), 32'hA5);
    check("fa5_par", 32'(bits[9]), 32'h1);
    check("fa5_stop", 32'(bits[10]), 32'h1);
    wait_sent();
    check("fa5_sent", 32'(sent_cnt), 32'h1);

`ifdef MOUSE_TX_TIMEOUT_EN
    sent_cnt = 0;
    request(8'h5A, 1'b0);
    wait_release(ok);
    dev_clocks(4, 1'b1, bits);
    repeat (TMO + 20) @(negedge clk);
    check("tmo_outs", 32'(outs()), 32'h0);
    check("tmo_sent", 32'(sent_cnt), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
